// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder with carry-in.
// Each of STAGES register stages adds one CHUNK = WIDTH/STAGES slice and hands
// its carry to the next stage. Valid/ready handshake on both sides with a
// single global advance enable, so the whole pipeline moves or holds as one.
// WIDTH must be a multiple of STAGES.
// Optional feature macro: PIPE_ADDER_OVF_EN adds the signed overflow output Ovf,
// pipelined alongside its result.
module pipe_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Per-stage registers. Operands ride along in full so later stages can pick
   // their own chunk; the sum register accumulates the low chunks produced so far.
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];

   // Stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
   logic [WIDTH-1:0]  a_src   [STAGES];
   logic [WIDTH-1:0]  b_src   [STAGES];
   logic [WIDTH-1:0]  s_src   [STAGES];
   logic [STAGES-1:0] c_src;
   logic [STAGES-1:0] v_src;

   // Combinational results of each stage before registering.
   logic [CHUNK:0]    part     [STAGES];
   logic [WIDTH-1:0]  sum_calc [STAGES];

   logic en;

`ifdef PIPE_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   logic ovf_calc;
`endif

   // Advance whenever the output slot is empty or being taken this cycle.
   always_comb begin
      en = out_ready || !valid_q[LAST];
   end

   assign in_ready  = en;
   assign out_valid = valid_q[LAST];
   assign Sum       = sum_q[LAST];
   assign Carry     = carry_q[LAST];
`ifdef PIPE_ADDER_OVF_EN
   assign Ovf       = ovf_q;
`endif

   // Wire each stage to its predecessor (or to the input ports for stage 0).
   always_comb begin
      a_src[0] = A;
      b_src[0] = B;
      s_src[0] = '0;
      c_src[0] = Cin;
      v_src[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = sum_q[k-1];
         c_src[k] = carry_q[k-1];
         v_src[k] = valid_q[k-1];
      end
   end

   // Chunk adders: stage k adds slice k plus the incoming carry and drops the
   // result into its slot of the accumulated sum.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_src[k]};
         sum_calc[k] = s_src[k];
         sum_calc[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      end
   end

   // Next-state: load from predecessor when enabled, otherwise hold everything.
   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      for (int k = 0; k < STAGES; k++) begin
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
         if (en) begin
            valid_d[k] = v_src[k];
            carry_d[k] = part[k][CHUNK];
            a_d[k]     = a_src[k];
            b_d[k]     = b_src[k];
            sum_d[k]   = sum_calc[k];
         end
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   // Signed overflow is decided in the last stage, where the MSB of the sum is
   // produced; it travels with its result and holds during stalls.
   always_comb begin
      ovf_calc = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
                 (sum_calc[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
      ovf_d    = en ? ovf_calc : ovf_q;
   end
`endif

   // Stage registers with synchronous reset clearing all in-flight data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
`ifdef PIPE_ADDER_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
`ifdef PIPE_ADDER_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed self-checking bench for pipe_adder (WIDTH=8, STAGES=4).
// Directed vectors carry hand-computed sums; a negedge monitor keeps a queue of
// accepted operand sets and checks every delivered result plus stall stability.
// Build with PIPE_ADDER_OVF_EN defined to also check the Ovf output.
module tb_pipe_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_drv;
   logic [7:0] b_drv;
   logic       cin_drv;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum_w;
   logic       carry_w;
`ifdef PIPE_ADDER_OVF_EN
   logic       ovf_w;
`endif

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   // Expected {ovf, carry, sum} of each accepted operand set, in order.
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(8), .STAGES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_drv),
      .B         (b_drv),
      .Cin       (cin_drv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (sum_w),
      .Carry     (carry_w)
`ifdef PIPE_ADDER_OVF_EN
      ,
      .Ovf       (ovf_w)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: full-precision sum and signed overflow of one operand set.
   function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] s;
      logic       v;
      s = {1'b0, a} + {1'b0, b} + {8'h00, c};
      v = (a[7] == b[7]) && (s[7] != a[7]);
      return {v, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop/compare on output transfers, push on input transfers,
   // and require outputs to stay frozen across stalled cycles.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_sum;
   logic       prev_carry;
   always @(negedge clk) begin
      logic [9:0] e;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_sum", sum_w, prev_sum);
            check_eq("stall_carry", carry_w, prev_carry);
         end
         if (out_valid && out_ready) begin
            check_eq("result_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               pops++;
               $display("OUT %0d: sum=%02h carry=%0b exp_sum=%02h exp_carry=%0b",
                        pops, sum_w, carry_w, e[7:0], e[8]);
               check_eq("stream_sum", sum_w, e[7:0]);
               check_eq("stream_carry", carry_w, e[8]);
`ifdef PIPE_ADDER_OVF_EN
               check_eq("stream_ovf", ovf_w, e[9]);
`endif
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(ref_add(a_drv, b_drv, cin_drv));
         prev_stall = out_valid && !out_ready;
         prev_sum   = sum_w;
         prev_carry = carry_w;
      end
   end

   // One operand set in an empty pipeline: latency and hand-computed result.
   task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
      a_drv = a; b_drv = b; cin_drv = c; in_valid = 1'b1;
      #1;
      check_eq({tag, "_in_ready"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         check_eq({tag, "_latency"}, out_valid, (n == 4) ? 1 : 0);
         if (n < 4) step();
      end
      check_eq({tag, "_sum"}, sum_w, es);
      check_eq({tag, "_carry"}, carry_w, ec);
`ifdef PIPE_ADDER_OVF_EN
      check_eq({tag, "_ovf"}, ovf_w, eo);
`endif
      $display("VEC %s: A=%02h B=%02h Cin=%0b exp_sum=%02h exp_carry=%0b exp_ovf=%0b",
               tag, a, b, c, es, ec, eo);
      step();
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) step();
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   task automatic new_operands();
      a_drv   = 8'($urandom_range(0, 255));
      b_drv   = 8'($urandom_range(0, 255));
      cin_drv = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int accepted;
      int seen;
      logic took;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a_drv = 8'h00; b_drv = 8'h00; cin_drv = 1'b0;
      step();
      step();
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_sum", sum_w, 0);
      check_eq("reset_carry", carry_w, 0);
      rst = 1'b0;
      #1;
      check_eq("reset_in_ready", in_ready, 1);
      step();

      // Directed vectors with hand-computed results.
      single("v01",   8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
      single("ffp1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      single("ripple",8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      single("ovfpos",8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      single("ovfneg",8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      single("noovf", 8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0);
      single("cin",   8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0);

      // Back-to-back stream of 16 with out_ready held high.
      base = pops;
      for (int c = 0; c < 22; c++) begin
         check_eq("stream_out_valid", out_valid, (c >= 4 && c < 20) ? 1 : 0);
         in_valid = (c < 16);
         new_operands();
         #1;
         if (c < 16) check_eq("stream_in_ready", in_ready, 1);
         step();
      end
      in_valid = 1'b0;
      drain(10);
      check_eq("stream_count", pops - base, 16);

      // Stream with a 5-cycle output stall.
      base = pops;
      accepted = 0;
      new_operands();
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 8 && c < 13);
         in_valid  = (accepted < 20);
         #1;
         if (c >= 8 && c < 13) check_eq("stall_in_ready", in_ready, 0);
         took = in_valid && in_ready;
         step();
         if (took) begin
            accepted++;
            new_operands();
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(10);
      check_eq("stall_accepted", accepted, 20);
      check_eq("stall_count", pops - base, 20);

      // Reset with data in flight: nothing issued before reset may come out.
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         new_operands();
         step();
      end
      rst = 1'b1;
      in_valid = 1'b1;
      new_operands();
      step();
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_sum", sum_w, 0);
      check_eq("midrst_carry", carry_w, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         seen += int'(out_valid);
         step();
      end
      check_eq("midrst_quiet", seen, 0);

      // Pipeline still works after the reset.
      single("post_rst", 8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
